// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, command types and FSM states.
// Optional sticky flag outputs are enabled in the top with ALU_SEQ_STICKY_FLAGS_EN.
package alu_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_ROR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NEG = 3'd7
  } aluOp_t;

  typedef enum logic {
    CMD_LOAD = 1'b0,
    CMD_ALU  = 1'b1
  } cmdType_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } seqState_t;

  // Wide enough for the largest settle count (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_cmd_sequencer_regfile.sv
// NREGS x DW register file with two asynchronous read ports and one synchronous write port.
// All registers clear to zero on asynchronous reset.
module alu_cmd_sequencer_regfile #(
  parameter int DW    = 16,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic [AW-1:0] rdAddrA,
  input  logic [AW-1:0] rdAddrB,
  output logic [DW-1:0] rdDataA,
  output logic [DW-1:0] rdDataB
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for ALU16bit: register file, issue/settle/capture FSM and response port.
// Define ALU_SEQ_STICKY_FLAGS_EN to add clr_sticky / sticky_z / sticky_c.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DW       = 16,
  parameter int NREGS    = 8,
  parameter int ALU_WAIT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_type,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [DW-1:0] cmd_imm,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_z,
  input  logic          alu_c,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_y,
  output logic          rsp_z,
  output logic          rsp_c,
  output logic [AW-1:0] rsp_rd
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  ,
  input  logic          clr_sticky,
  output logic          sticky_z,
  output logic          sticky_c
`endif
);

  seqState_t      state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic [AW-1:0]  rdLatch;
  logic           accept, aluAccept, loadAccept;
  logic           regWrEn;
  logic [AW-1:0]  regWrAddr;
  logic [DW-1:0]  regWrData;
  logic [DW-1:0]  regA, regB;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign aluAccept  = accept & (cmd_type == CMD_ALU);
  assign loadAccept = accept & (cmd_type == CMD_LOAD);

  // LOAD writes happen in IDLE and ALU writebacks in CAPTURE, so they never collide.
  assign regWrEn   = loadAccept | (state == CAPTURE);
  assign regWrAddr = (state == CAPTURE) ? rdLatch : cmd_rd;
  assign regWrData = (state == CAPTURE) ? alu_y : cmd_imm;

  alu_cmd_sequencer_regfile #(.DW(DW), .NREGS(NREGS), .AW(AW)) uRegfile (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (regWrEn),
    .wrAddr  (regWrAddr),
    .wrData  (regWrData),
    .rdAddrA (cmd_ra),
    .rdAddrB (cmd_rb),
    .rdDataA (regA),
    .rdDataB (regB)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (aluAccept) nextState = ISSUE;
      ISSUE:   if (waitCnt == CNT_W'(1)) nextState = CAPTURE;
      CAPTURE: nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ALU drive registers hold their last issued values until the next ALU accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rdLatch   <= '0;
      waitCnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_z     <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_rd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aluAccept) begin
            alu_op  <= cmd_op;
            alu_a   <= regA;
            alu_b   <= regB;
            rdLatch <= cmd_rd;
            waitCnt <= CNT_W'(ALU_WAIT);
          end
        end
        ISSUE: waitCnt <= waitCnt - CNT_W'(1);
        CAPTURE: begin
          rsp_y     <= alu_y;
          rsp_z     <= alu_z;
          rsp_c     <= alu_c;
          rsp_rd    <= rdLatch;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // A flag raised at CAPTURE takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_z <= 1'b0;
      sticky_c <= 1'b0;
    end else begin
      if ((state == CAPTURE) && alu_z) sticky_z <= 1'b1;
      else if (clr_sticky)             sticky_z <= 1'b0;
      if ((state == CAPTURE) && alu_c) sticky_c <= 1'b1;
      else if (clr_sticky)             sticky_c <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed scoreboard bench for alu_cmd_sequencer with a behavioural ALU16bit stand-in.
// Define ALU_SEQ_STICKY_FLAGS_EN to also exercise the sticky flag outputs.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_type;
  logic [2:0]    cmd_op, alu_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb, rsp_rd;
  logic [DW-1:0] cmd_imm, alu_a, alu_b, alu_y, rsp_y;
  logic          alu_z, alu_c, rsp_valid, rsp_ready, rsp_z, rsp_c;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic          clr_sticky, sticky_z, sticky_c;
`endif

  typedef struct {
    logic [DW-1:0] y;
    logic          z;
    logic          c;
    logic [AW-1:0] rd;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] shadow [8];
  int            checks = 0;
  int            errors = 0;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_rd(rsp_rd)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    , .clr_sticky(clr_sticky), .sticky_z(sticky_z), .sticky_c(sticky_c)
`endif
  );

  // Returns {c, z, y}; c is carry for ADD, borrow for SUB, the shifted-out bit for shifts.
  function automatic logic [17:0] aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] wide;
    logic        carry;
    logic [15:0] y;
    wide  = '0;
    carry = 1'b0;
    y     = '0;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; y = wide[15:0]; carry = wide[16]; end
      3'd1: begin wide = {1'b0, a} - {1'b0, b}; y = wide[15:0]; carry = wide[16]; end
      3'd2: begin y = {a[14:0], 1'b0}; carry = a[15]; end
      3'd3: begin y = {a[0], a[15:1]}; carry = a[0]; end
      3'd4: y = a & b;
      3'd5: y = a | b;
      3'd6: y = a ^ b;
      default: begin y = 16'd0 - a; carry = (a != 16'd0); end
    endcase
    return {carry, (y == 16'd0), y};
  endfunction

  always_comb {alu_c, alu_z, alu_y} = aluRef(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadReg(input logic [AW-1:0] rd, input logic [DW-1:0] imm);
    chk("load_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_type = CMD_LOAD; cmd_rd = rd; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    shadow[rd] = imm;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [AW-1:0] rd,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    rsp_t        e;
    logic [17:0] r;
    chk("alu_ready", cmd_ready, 1);
    r    = aluRef(op, shadow[ra], shadow[rb]);
    e.y  = r[15:0];
    e.z  = r[16];
    e.c  = r[17];
    e.rd = rd;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_type = CMD_ALU; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_type  = CMD_LOAD;
  endtask

  task automatic checkOutput(input string tag, input int holdCycles);
    rsp_t e;
    int   cycles;
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, "_latency"}, cycles, 2);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!rsp_valid) return;
    chk({tag, "_y"}, rsp_y, e.y);
    chk({tag, "_z"}, rsp_z, e.z);
    chk({tag, "_c"}, rsp_c, e.c);
    chk({tag, "_rd"}, rsp_rd, e.rd);
    shadow[e.rd] = e.y;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_y"}, rsp_y, e.y);
      chk({tag, "_hold_rd"}, rsp_rd, e.rd);
      chk({tag, "_hold_cmdready"}, cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_release_valid"}, rsp_valid, 0);
    chk({tag, "_release_cmdready"}, cmd_ready, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_type = CMD_LOAD; cmd_op = '0;
    cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; rsp_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp", {rsp_y, rsp_z, rsp_c, rsp_rd}, 0);

    // Basic add, then read R3 back through an AND with itself.
    loadReg(3'd1, 16'h000F);
    loadReg(3'd2, 16'h000F);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2);
    checkOutput("add", 0);
    chk("add_const_y", rsp_y, 16'h001E);
    chk("add_const_zc", {rsp_z, rsp_c}, 0);
    chk("add_const_rd", rsp_rd, 3);
    chk("alu_a_kept", alu_a, 16'h000F);
    chk("alu_op_kept", alu_op, OP_ADD);
    applyStimulus(OP_AND, 3'd3, 3'd3, 3'd3);
    checkOutput("r3_read", 0);
    chk("r3_const", rsp_y, 16'h001E);

    // Subtraction, including a zero result.
    loadReg(3'd4, 16'h0070);
    loadReg(3'd5, 16'h0010);
    applyStimulus(OP_SUB, 3'd6, 3'd4, 3'd5);
    checkOutput("sub", 0);
    chk("sub_const", rsp_y, 16'h0060);
    applyStimulus(OP_SUB, 3'd7, 3'd4, 3'd4);
    checkOutput("sub_zero", 0);
    chk("sub_zero_const", {rsp_y, rsp_z}, {16'h0000, 1'b1});

    // Rd aliasing an operand, and the following command seeing the writeback.
    loadReg(3'd1, 16'h0101);
    loadReg(3'd2, 16'h1110);
    applyStimulus(OP_XOR, 3'd1, 3'd1, 3'd2);
    checkOutput("xor", 0);
    chk("xor_const", rsp_y, 16'h1011);
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd1);
    checkOutput("waw", 0);
    chk("waw_const", rsp_y, 16'h2022);

    // Back-pressure with a competing LOAD that must be ignored.
    applyStimulus(OP_ADD, 3'd6, 3'd6, 3'd5);
    cmd_valid = 1'b1; cmd_type = CMD_LOAD; cmd_rd = 3'd5; cmd_imm = 16'hDEAD;
    checkOutput("hold", 5);
    applyStimulus(OP_AND, 3'd5, 3'd5, 3'd5);
    checkOutput("ignored_load", 0);
    chk("ignored_load_const", rsp_y, 16'h0010);

    // Shift, rotate and negate.
    loadReg(3'd1, 16'h8001);
    applyStimulus(OP_SHL, 3'd2, 3'd1, 3'd1);
    checkOutput("shl", 0);
    applyStimulus(OP_ROR, 3'd3, 3'd1, 3'd1);
    checkOutput("ror", 0);
    applyStimulus(OP_NEG, 3'd4, 3'd1, 3'd1);
    checkOutput("neg", 0);
    chk("neg_const", {rsp_c, rsp_y}, {1'b1, 16'h7FFF});

    // Reset while the command is in ISSUE.
    applyStimulus(OP_OR, 3'd2, 3'd1, 3'd1);
    reset = 1'b1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    applyStimulus(OP_AND, 3'd2, 3'd2, 3'd2);
    checkOutput("abort_rd", 0);
    chk("abort_rd_const", rsp_y, 16'h0000);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    chk("sticky_rst", {sticky_z, sticky_c}, 0);
    loadReg(3'd1, 16'hFFFF);
    loadReg(3'd2, 16'h0001);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2);
    checkOutput("sticky_add", 0);
    chk("sticky_add_const", {rsp_c, rsp_z, rsp_y}, {2'b11, 16'h0000});
    chk("sticky_c_set", sticky_c, 1);
    chk("sticky_z_set", sticky_z, 1);
    applyStimulus(OP_AND, 3'd4, 3'd2, 3'd2);
    checkOutput("sticky_and", 0);
    chk("sticky_c_persist", sticky_c, 1);
    chk("sticky_z_persist", sticky_z, 1);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", {sticky_z, sticky_c}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
